// File: rtl/vram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_pkg : shared types and helpers for the VRAM request responder   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } vram_state_t;

  typedef logic [3:0] nibble_mask_t;

  function automatic int fb_aw(input int width, input int height);
    return $clog2(width * height);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_dp_bram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_dp_bram : true dual-port 16-bit RAM, nibble-write port A, RO B  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module vram_dp_bram
  import vram_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  nibble_mask_t      a_mask,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic [15:0]       a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [15:0]       b_rdata
);

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (a_en && a_we) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) begin
          mem[a_addr][4*i +: 4] <= a_wdata[4*i +: 4];
        end
      end
    end
  end

  // Port A read register only loads on an access, so it holds between them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en) begin
        a_rdata <= mem[a_addr];
      end
      b_rdata <= mem[b_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_responder : VRAM bus target over a double-buffered framebuffer  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module vram_responder
  import vram_pkg::*;
#(
  parameter int FB_WIDTH    = 256,
  parameter int FB_HEIGHT   = 256,
  parameter int WAIT_STATES = 1,
  localparam int AW         = fb_aw(FB_WIDTH, FB_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          vram_sel_i,
  input  logic          vram_wr_i,
  input  logic [3:0]    vram_mask_i,
  input  logic [31:0]   vram_addr_i,
  input  logic [15:0]   vram_data_in_i,
  output logic [15:0]   vram_data_out_o,
  output logic          vram_ack_o,
  input  logic          swap_i,
  output logic          front_buffer_o,
  input  logic [AW-1:0] disp_addr_i,
  output logic [15:0]   disp_data_o
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_ACK    = ACK;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          swap_pending;
  logic          front;
  logic          req_wr;
  nibble_mask_t  req_mask;
  logic [15:0]   req_data;
  logic [AW-1:0] req_addr;
  logic          req_bank;
  logic          unused_addr_bits;

  // Upper address bits are deliberately discarded; the buffer wraps.
  assign unused_addr_bits = ^vram_addr_i[31:AW];

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      swap_pending <= 1'b0;
      front        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vram_sel_i) begin
            state <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= ST_ACCESS;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ACCESS: state <= ST_ACK;
        ST_ACK:    state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      // A swap never lands mid-transaction; it waits for the edge leaving ACK.
      if (state == ST_ACK) begin
        if (swap_pending || swap_i) begin
          front <= ~front;
        end
        swap_pending <= 1'b0;
      end else if (state == ST_IDLE && !vram_sel_i) begin
        if (swap_i) begin
          front <= ~front;
        end
      end else if (swap_i) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && vram_sel_i) begin
      req_wr   <= vram_wr_i;
      req_mask <= vram_mask_i;
      req_data <= vram_data_in_i;
      req_addr <= vram_addr_i[AW-1:0];
      req_bank <= ~front;
    end
  end

  vram_dp_bram #(
    .ADDR_W (AW + 1)
  ) u_bram (
    .clk     (clk),
    .rst_n   (reset_i),
    .a_en    (state == ST_ACCESS),
    .a_we    (req_wr),
    .a_mask  (req_mask),
    .a_addr  ({req_bank, req_addr}),
    .a_wdata (req_data),
    .a_rdata (vram_data_out_o),
    .b_addr  ({front, disp_addr_i}),
    .b_rdata (disp_data_o)
  );

  assign vram_ack_o     = (state == ST_ACK);
  assign front_buffer_o = front;

endmodule
`default_nettype wire

// File: tb/tb_vram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vram_responder : directed self-checking bench for vram_responder  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_vram_responder;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          vram_sel_i;
  logic          vram_wr_i;
  logic [3:0]    vram_mask_i;
  logic [31:0]   vram_addr_i;
  logic [15:0]   vram_data_in_i;
  logic [15:0]   vram_data_out_o;
  logic          vram_ack_o;
  logic          swap_i;
  logic          front_buffer_o;
  logic [AW-1:0] disp_addr_i;
  logic [15:0]   disp_data_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vram_responder #(
    .FB_WIDTH    (256),
    .FB_HEIGHT   (256),
    .WAIT_STATES (1)
  ) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .vram_sel_i      (vram_sel_i),
    .vram_wr_i       (vram_wr_i),
    .vram_mask_i     (vram_mask_i),
    .vram_addr_i     (vram_addr_i),
    .vram_data_in_i  (vram_data_in_i),
    .vram_data_out_o (vram_data_out_o),
    .vram_ack_o      (vram_ack_o),
    .swap_i          (swap_i),
    .front_buffer_o  (front_buffer_o),
    .disp_addr_i     (disp_addr_i),
    .disp_data_o     (disp_data_o)
  );

  // Called at a negedge; returns at the negedge of the ack cycle with sel still high.
  task automatic bus_req(input logic wr, input logic [3:0] mask, input logic [31:0] addr,
                         input logic [15:0] data, output logic [15:0] rdata, output int lat);
    vram_sel_i     = 1'b1;
    vram_wr_i      = wr;
    vram_mask_i    = mask;
    vram_addr_i    = addr;
    vram_data_in_i = data;
    lat            = -1;
    rdata          = 16'hxxxx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (vram_ack_o) begin
        lat   = k;
        rdata = vram_data_out_o;
        break;
      end
    end
  endtask

  task automatic idle_cycle();
    vram_sel_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i     = 1'b0;
    disp_addr_i = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    compared++; if (vram_ack_o !== 1'b0) begin mismatched++; $display("FAIL reset_ack: got %b want 0", vram_ack_o); end
    compared++; if (vram_data_out_o !== 16'h0000) begin mismatched++; $display("FAIL reset_dout: got %h want 0000", vram_data_out_o); end
    compared++; if (front_buffer_o !== 1'b0) begin mismatched++; $display("FAIL reset_front: got %b want 0", front_buffer_o); end
    compared++; if (disp_data_o !== 16'h0000) begin mismatched++; $display("FAIL reset_disp: got %h want 0000", disp_data_o); end
    reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [15:0] rd;
    int lat;
    bus_req(1'b1, 4'hF, 32'd5, 16'hABCD, rd, lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL wr_latency: got %0d want 3", lat); end
    idle_cycle();
    compared++; if (vram_ack_o !== 1'b0) begin mismatched++; $display("FAIL ack_one_cycle: got %b want 0", vram_ack_o); end
    bus_req(1'b0, 4'hF, 32'd5, 16'h0000, rd, lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL rd_latency: got %0d want 3", lat); end
    compared++; if (rd !== 16'hABCD) begin mismatched++; $display("FAIL rd_data: got %h want abcd", rd); end
    idle_cycle();
  endtask

  task automatic test_mask();
    logic [15:0] rd;
    int lat;
    bus_req(1'b1, 4'hF, 32'd7, 16'h1234, rd, lat);
    idle_cycle();
    bus_req(1'b1, 4'b0101, 32'd7, 16'hFFFF, rd, lat);
    idle_cycle();
    bus_req(1'b0, 4'hF, 32'd7, 16'h0000, rd, lat);
    compared++; if (rd !== 16'h1F3F) begin mismatched++; $display("FAIL mask_0101: got %h want 1f3f", rd); end
    idle_cycle();
    bus_req(1'b1, 4'h0, 32'd7, 16'h0000, rd, lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL mask0_ack: got lat %0d want 3", lat); end
    idle_cycle();
    bus_req(1'b0, 4'hF, 32'd7, 16'h0000, rd, lat);
    compared++; if (rd !== 16'h1F3F) begin mismatched++; $display("FAIL mask_0000: got %h want 1f3f", rd); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    int lat;
    bus_req(1'b1, 4'hF, 32'h0001_0005, 16'h7777, rd, lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL b2b_first_lat: got %0d want 3", lat); end
    bus_req(1'b0, 4'hF, 32'd5, 16'h0000, rd, lat);
    compared++; if (lat !== 4) begin mismatched++; $display("FAIL b2b_spacing1: got %0d want 4", lat); end
    compared++; if (rd !== 16'h7777) begin mismatched++; $display("FAIL alias_write: got %h want 7777", rd); end
    bus_req(1'b0, 4'hF, 32'hFFFF_0005, 16'h0000, rd, lat);
    compared++; if (lat !== 4) begin mismatched++; $display("FAIL b2b_spacing2: got %0d want 4", lat); end
    compared++; if (rd !== 16'h7777) begin mismatched++; $display("FAIL alias_read: got %h want 7777", rd); end
    idle_cycle();
  endtask

  task automatic test_swap_idle();
    logic [15:0] rd;
    int lat;
    bus_req(1'b1, 4'hF, 32'd0, 16'h00AA, rd, lat);
    idle_cycle();
    swap_i      = 1'b1;
    disp_addr_i = '0;
    @(posedge clk);
    @(negedge clk);
    swap_i = 1'b0;
    compared++; if (front_buffer_o !== 1'b1) begin mismatched++; $display("FAIL swap_idle_front: got %b want 1", front_buffer_o); end
    @(posedge clk);
    @(negedge clk);
    compared++; if (disp_data_o !== 16'h00AA) begin mismatched++; $display("FAIL swap_idle_disp: got %h want 00aa", disp_data_o); end
  endtask

  task automatic test_swap_inflight();
    vram_sel_i     = 1'b1;
    vram_wr_i      = 1'b1;
    vram_mask_i    = 4'hF;
    vram_addr_i    = 32'd3;
    vram_data_in_i = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    swap_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    swap_i = 1'b0;
    compared++; if (vram_ack_o !== 1'b1) begin mismatched++; $display("FAIL inflight_ack: got %b want 1", vram_ack_o); end
    compared++; if (front_buffer_o !== 1'b1) begin mismatched++; $display("FAIL inflight_front_hold: got %b want 1", front_buffer_o); end
    vram_sel_i  = 1'b0;
    disp_addr_i = 16'd3;
    @(posedge clk);
    @(negedge clk);
    compared++; if (front_buffer_o !== 1'b0) begin mismatched++; $display("FAIL inflight_front_toggle: got %b want 0", front_buffer_o); end
    @(posedge clk);
    @(negedge clk);
    compared++; if (disp_data_o !== 16'hBEEF) begin mismatched++; $display("FAIL inflight_old_back: got %h want beef", disp_data_o); end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    compared++; if (front_buffer_o !== 1'b0) begin mismatched++; $display("FAIL inflight_single_toggle: got %b want 0", front_buffer_o); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] rd;
    int lat;
    bus_req(1'b1, 4'hF, 32'd9, 16'h5555, rd, lat);
    idle_cycle();
    bus_req(1'b0, 4'hF, 32'd9, 16'h0000, rd, lat);
    compared++; if (rd !== 16'h5555) begin mismatched++; $display("FAIL pre_reset_rd: got %h want 5555", rd); end
    idle_cycle();
    compared++; if (disp_data_o !== 16'hBEEF) begin mismatched++; $display("FAIL pre_reset_disp: got %h want beef", disp_data_o); end
    vram_sel_i     = 1'b1;
    vram_wr_i      = 1'b1;
    vram_mask_i    = 4'hF;
    vram_addr_i    = 32'd9;
    vram_data_in_i = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    reset_i    = 1'b0;
    vram_sel_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compared++; if (vram_ack_o !== 1'b0) begin mismatched++; $display("FAIL midop_ack: got %b want 0", vram_ack_o); end
    compared++; if (vram_data_out_o !== 16'h0000) begin mismatched++; $display("FAIL midop_dout: got %h want 0000", vram_data_out_o); end
    compared++; if (front_buffer_o !== 1'b0) begin mismatched++; $display("FAIL midop_front: got %b want 0", front_buffer_o); end
    compared++; if (disp_data_o !== 16'h0000) begin mismatched++; $display("FAIL midop_disp: got %h want 0000", disp_data_o); end
    reset_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    compared++; if (vram_ack_o !== 1'b0) begin mismatched++; $display("FAIL midop_no_late_ack: got %b want 0", vram_ack_o); end
    bus_req(1'b0, 4'hF, 32'd9, 16'h0000, rd, lat);
    compared++; if (rd !== 16'h5555) begin mismatched++; $display("FAIL midop_ram_kept: got %h want 5555", rd); end
    idle_cycle();
  endtask

  initial begin
    reset_i        = 1'b0;
    vram_sel_i     = 1'b0;
    vram_wr_i      = 1'b0;
    vram_mask_i    = 4'h0;
    vram_addr_i    = '0;
    vram_data_in_i = '0;
    swap_i         = 1'b0;
    disp_addr_i    = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_mask();
    test_back_to_back();
    test_swap_idle();
    test_swap_inflight();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
